// File: rtl/mmd_ratio_ctrl_pkg.sv
// mmd_ratio_ctrl_pkg: shared widths, enums and the divider clamp helper
// for the MMD division-ratio scheduler.
package mmd_ratio_ctrl_pkg;

    localparam int DIVNUM_W = 9;
    localparam int SUM_W    = 11;

    typedef enum logic [1:0] {
        MODE_INT    = 2'd0,
        MODE_MASH1  = 2'd1,
        MODE_MASH11 = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_e;

    typedef struct packed {
        logic                hit;
        logic [DIVNUM_W-1:0] value;
    } clamp_t;

    // Reserved mode encoding 3 runs as plain integer division.
    function automatic mode_e decode_mode(input logic [1:0] raw);
        case (raw)
            2'd1:    return MODE_MASH1;
            2'd2:    return MODE_MASH11;
            default: return MODE_INT;
        endcase
    endfunction

    // Signed ratio limited to [lo, hi]; hit flags that limiting took place.
    function automatic clamp_t clamp_div(input logic signed [SUM_W-1:0] sum,
                                         input logic [DIVNUM_W-1:0]     lo,
                                         input logic [DIVNUM_W-1:0]     hi);
        clamp_t r;
        r.hit   = 1'b0;
        r.value = sum[DIVNUM_W-1:0];
        if (sum < $signed(SUM_W'(lo))) begin
            r.hit   = 1'b1;
            r.value = lo;
        end else if (sum > $signed(SUM_W'(hi))) begin
            r.hit   = 1'b1;
            r.value = hi;
        end
        return r;
    endfunction

endpackage

// File: rtl/mmd_ratio_ctrl_if.sv
// mmd_ratio_ctrl_if: ratio configuration bus (valid/ready handshake plus
// mode, integer and fractional ratio words).
interface mmd_ratio_ctrl_if #(
    parameter int FRAC_W = 16
);
    import mmd_ratio_ctrl_pkg::*;

    logic                CFG_VALID;
    logic                CFG_READY;
    logic [1:0]          CFG_MODE;
    logic [DIVNUM_W-1:0] CFG_NINT;
    logic [FRAC_W-1:0]   CFG_NFRAC;

    modport master (
        output CFG_VALID,
        output CFG_MODE,
        output CFG_NINT,
        output CFG_NFRAC,
        input  CFG_READY
    );

    modport slave (
        input  CFG_VALID,
        input  CFG_MODE,
        input  CFG_NINT,
        input  CFG_NFRAC,
        output CFG_READY
    );

endinterface

// File: rtl/mmd_ratio_ctrl_mash.sv
// mmd_mash_acc: one modular FRAC_W-bit accumulator stage of the MASH
// modulator. sum/carry are the combinational result of this edge's add,
// so a following stage can chain on the updated value in the same cycle.
module mmd_mash_acc #(
    parameter int FRAC_W = 16
) (
    input  logic              CKVD,
    input  logic              NARST,
    input  logic              clr,
    input  logic              en,
    input  logic              cin,
    input  logic [FRAC_W-1:0] din,
    output logic [FRAC_W-1:0] sum,
    output logic              carry
);

    logic [FRAC_W-1:0] acc_q;
    logic [FRAC_W:0]   total;

    // Extra carry-in lets a dither bit ride on the input without overflowing din.
    assign total = {1'b0, acc_q} + {1'b0, din} + {{FRAC_W{1'b0}}, cin};
    assign sum   = total[FRAC_W-1:0];
    assign carry = total[FRAC_W];

    // Accumulator register: clear has priority over stepping.
    always_ff @(posedge CKVD or negedge NARST) begin
        if (!NARST) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= sum;
        end
    end

endmodule

// File: rtl/mmd_ratio_ctrl.sv
// mmd_ratio_ctrl: division-ratio scheduler for the 9-bit MMD in the PLL
// feedback path. One DIVNUM word per divided cycle, integer / MASH-1 /
// MASH-1-1 modulation, output clamped to [DIV_MIN, DIV_MAX].
// Optional build macro: MMD_RATIO_CTRL_DITHER_EN adds a 15-bit LFSR whose
// output is injected into the LSB of the first accumulator in MASH modes.
//
// state | meaning
// IDLE  | after reset, DIVNUM held at DIV_DEFAULT, ready for a config
// LOAD  | one edge: accumulators cleared, DIVNUM <= clamp(nint)
// RUN   | modulator steps every edge; a new config restarts via LOAD
module mmd_ratio_ctrl
    import mmd_ratio_ctrl_pkg::*;
#(
    parameter int                  FRAC_W      = 16,
    parameter logic [DIVNUM_W-1:0] DIV_MIN     = 9'd4,
    parameter logic [DIVNUM_W-1:0] DIV_MAX     = 9'd511,
    parameter logic [DIVNUM_W-1:0] DIV_DEFAULT = 9'd16
) (
    input  logic                CKVD,
    input  logic                NARST,
    mmd_ratio_ctrl_if.slave     cfg,
    output logic [DIVNUM_W-1:0] DIVNUM,
    output logic                SAT,
    output logic                RUNNING
);

    state_e                     state_q;
    state_e                     state_d;
    logic                       cfg_ready;
    logic                       accept;

    mode_e                      mode_q;
    logic [DIVNUM_W-1:0]        nint_q;
    logic [FRAC_W-1:0]          nfrac_q;

    logic                       mash_mode;
    logic                       acc_clr;
    logic                       acc_en;
    logic                       dither_bit;
    logic [FRAC_W-1:0]          acc1_sum;
    logic [FRAC_W-1:0]          unused_acc2_sum;
    logic                       c1;
    logic                       c2;
    logic                       c2_d_q;

    logic signed [SUM_W-1:0]    y;
    logic signed [SUM_W-1:0]    y_eff;
    logic signed [SUM_W-1:0]    ratio_sum;
    clamp_t                     clamp_res;

    logic [DIVNUM_W-1:0]        divnum_q;
    logic                       sat_q;

    // Ready is withheld only during the single LOAD edge.
    assign cfg_ready     = (state_q != LOAD);
    assign cfg.CFG_READY = cfg_ready;
    assign accept        = cfg.CFG_VALID && cfg_ready;

    // State register.
    always_ff @(posedge CKVD or negedge NARST) begin
        if (!NARST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: any acceptance restarts through LOAD; RUN is terminal.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = LOAD;
            LOAD:    state_d = RUN;
            RUN:     if (accept) state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    // Configuration capture on each accepted handshake.
    always_ff @(posedge CKVD or negedge NARST) begin
        if (!NARST) begin
            mode_q  <= MODE_INT;
            nint_q  <= '0;
            nfrac_q <= '0;
        end else if (accept) begin
            mode_q  <= decode_mode(cfg.CFG_MODE);
            nint_q  <= cfg.CFG_NINT;
            nfrac_q <= cfg.CFG_NFRAC;
        end
    end

    assign mash_mode = (mode_q == MODE_MASH1) || (mode_q == MODE_MASH11);
    assign acc_clr   = (state_q == LOAD);
    assign acc_en    = (state_q == RUN) && mash_mode;

`ifdef MMD_RATIO_CTRL_DITHER_EN
    logic [14:0] lfsr_q;

    // x^15 + x^14 + 1 Fibonacci LFSR, advanced once per RUN edge.
    always_ff @(posedge CKVD or negedge NARST) begin
        if (!NARST) begin
            lfsr_q <= 15'h0001;
        end else if (state_q == RUN) begin
            lfsr_q <= {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
        end
    end

    assign dither_bit = lfsr_q[14] & mash_mode;
`else
    assign dither_bit = 1'b0;
`endif

    mmd_mash_acc #(.FRAC_W(FRAC_W)) u_acc1 (
        .CKVD  (CKVD),
        .NARST (NARST),
        .clr   (acc_clr),
        .en    (acc_en),
        .cin   (dither_bit),
        .din   (nfrac_q),
        .sum   (acc1_sum),
        .carry (c1)
    );

    // Second stage integrates the first stage's updated value.
    mmd_mash_acc #(.FRAC_W(FRAC_W)) u_acc2 (
        .CKVD  (CKVD),
        .NARST (NARST),
        .clr   (acc_clr),
        .en    (acc_en),
        .cin   (1'b0),
        .din   (acc1_sum),
        .sum   (unused_acc2_sum),
        .carry (c2)
    );

    // Delayed second-stage carry for the MASH-1-1 differentiator.
    always_ff @(posedge CKVD or negedge NARST) begin
        if (!NARST) begin
            c2_d_q <= 1'b0;
        end else if (state_q == LOAD) begin
            c2_d_q <= 1'b0;
        end else if (state_q == RUN) begin
            c2_d_q <= c2;
        end
    end

    // Modulator offset y in -1..+2 for the current mode.
    always_comb begin
        y = '0;
        unique case (mode_q)
            MODE_MASH1:  y = SUM_W'(c1);
            MODE_MASH11: y = SUM_W'(c1) + SUM_W'(c2) - SUM_W'(c2_d_q);
            default:     y = '0;
        endcase
    end

    // LOAD presents the bare integer ratio; RUN adds the modulator offset.
    assign y_eff     = (state_q == LOAD) ? '0 : y;
    assign ratio_sum = $signed(SUM_W'(nint_q)) + y_eff;
    assign clamp_res = clamp_div(ratio_sum, DIV_MIN, DIV_MAX);

    // DIVNUM and sticky SAT; a same-edge acceptance clear beats a clamp set.
    always_ff @(posedge CKVD or negedge NARST) begin
        if (!NARST) begin
            divnum_q <= DIV_DEFAULT;
            sat_q    <= 1'b0;
        end else begin
            if (state_q != IDLE) begin
                divnum_q <= clamp_res.value;
            end
            if (accept) begin
                sat_q <= 1'b0;
            end else if ((state_q != IDLE) && clamp_res.hit) begin
                sat_q <= 1'b1;
            end
        end
    end

    assign DIVNUM  = divnum_q;
    assign SAT     = sat_q;
    assign RUNNING = (state_q == RUN);

endmodule
